alu_ctrl_fsm: RTL and testbench

ALU_CTRL_FSM -- requirements
Module: alu_ctrl_fsm

---
 rtl/alu_ctrl_fsm.sv | 103 ++++++++++
 tb/tb_alu_ctrl_fsm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_fsm.sv
// Three-state command controller for an external 4:1 ALU result mux.
// Latches operands on accept, presents candidate results, captures the selected one with flags.
module alu_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    output logic [7:0] j,
    output logic [7:0] k,
    output logic [7:0] l,
    output logic [7:0] m,
    output logic [1:0] S,
    input  logic [7:0] Y,
    output logic [7:0] res,
    output logic       carry,
    output logic       zero,
    output logic       res_valid,
    input  logic       res_ready
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StHold = 2'b10
    } state_e;

    state_e     r_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [1:0] r_op;
    logic [7:0] r_res;
    logic       r_carry;
    logic       r_zero;

    logic [8:0] w_sum;
    logic [7:0] w_diff;
    logic       w_borrow;
    logic       w_carry;

    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff   = r_a - r_b;
    assign w_borrow = (r_a < r_b);

    // Flag source depends only on the latched opcode; logic ops never carry.
    always_comb begin
        w_carry = 1'b0;
        unique case (r_op)
            2'b00:   w_carry = w_sum[8];
            2'b01:   w_carry = w_borrow;
            default: w_carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_op    <= 2'b00;
            r_res   <= 8'h00;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    r_res   <= Y;
                    r_zero  <= (Y == 8'h00);
                    r_carry <= w_carry;
                    r_state <= StHold;
                end
                StHold: begin
                    if (res_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign j         = w_sum[7:0];
    assign k         = w_diff;
    assign l         = r_a & r_b;
    assign m         = r_a | r_b;
    assign S         = r_op;
    assign res       = r_res;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign in_ready  = (r_state == StIdle);
    assign res_valid = (r_state == StHold);

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Randomized self-checking bench for alu_ctrl_fsm with an arithmetic reference model
// and a behavioural 4:1 result mux closing the loop on S/Y.
module tb_alu_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] l;
    logic [7:0] m;
    logic [1:0] S;
    logic [7:0] Y;
    logic [7:0] res;
    logic       carry;
    logic       zero;
    logic       res_valid;
    logic       res_ready;

    int n_checks;
    int n_fail;

    alu_ctrl_fsm u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .j         (j),
        .k         (k),
        .l         (l),
        .m         (m),
        .S         (S),
        .Y         (Y),
        .res       (res),
        .carry     (carry),
        .zero      (zero),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream result mux.
    always_comb begin
        Y = 8'h00;
        case (S)
            2'b00: Y = j;
            2'b01: Y = k;
            2'b10: Y = l;
            2'b11: Y = m;
            default: Y = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: result and flags from plain integer arithmetic.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic [1:0] mop,
                         output logic [7:0] r, output logic c, output logic z);
        int ia;
        int ib;
        ia = int'(ma);
        ib = int'(mb);
        case (mop)
            2'd0: begin r = 8'((ia + ib) % 256);       c = (ia + ib) > 255; end
            2'd1: begin r = 8'((ia - ib + 256) % 256); c = ia < ib;         end
            2'd2: begin r = ma & mb;                   c = 1'b0;            end
            default: begin r = ma | mb;                c = 1'b0;            end
        endcase
        z = (r == 8'h00);
    endtask

    task automatic check_cands(input logic [7:0] ca, input logic [7:0] cb);
        logic [7:0] r;
        logic       c;
        logic       z;
        model(ca, cb, 2'd0, r, c, z); check("j_add", j, r);
        model(ca, cb, 2'd1, r, c, z); check("k_sub", k, r);
        model(ca, cb, 2'd2, r, c, z); check("l_and", l, r);
        model(ca, cb, 2'd3, r, c, z); check("m_or", m, r);
    endtask

    // One command: accept, EXEC with junk on inputs, HOLD for `hold` extra cycles, release.
    task automatic run_cmd(input logic [7:0] ca, input logic [7:0] cb, input logic [1:0] cop,
                           input int hold);
        logic [7:0] er;
        logic       ec;
        logic       ez;
        model(ca, cb, cop, er, ec, ez);
        a = ca; b = cb; op = cop; in_valid = 1'b1; res_ready = 1'b0;
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_res_valid", res_valid, 1'b0);
        tick();
        check("exec_in_ready", in_ready, 1'b0);
        check("exec_res_valid", res_valid, 1'b0);
        check("exec_S", S, cop);
        check_cands(ca, cb);
        in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
        tick();
        check("hold_res_valid", res_valid, 1'b1);
        check("hold_in_ready", in_ready, 1'b0);
        check("hold_res", res, er);
        check("hold_carry", carry, ec);
        check("hold_zero", zero, ez);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            tick();
            check("bp_res_valid", res_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_res", res, er);
            check("bp_carry", carry, ec);
            check("bp_zero", zero, ez);
            check("bp_S", S, cop);
        end
        res_ready = 1'b1; in_valid = 1'b0;
        tick();
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_res_valid", res_valid, 1'b0);
        check("rel_res_stable", res, er);
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] er;
        logic       ec;
        logic       ez;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [1:0] rop;
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        a = 8'hA5; b = 8'h5A; op = 2'b11;
        #23;
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_S", S, 2'b00);
        check("rst_jklm", {j, k, l, m}, 32'h0);
        check("rst_res", res, 8'h00);
        check("rst_flags", {carry, zero}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_cmd(8'h3C, 8'h05, 2'b00, 0);
        run_cmd(8'h05, 8'h3C, 2'b01, 0);
        run_cmd(8'hFF, 8'h01, 2'b00, 1);
        run_cmd(8'h77, 8'h77, 2'b01, 0);
        run_cmd(8'hF0, 8'h0F, 2'b10, 5);
        run_cmd(8'h00, 8'h00, 2'b11, 2);

        // Reset during EXEC abandons the command.
        a = 8'h10; b = 8'h20; op = 2'b11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pre_rst_exec", in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", res_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_res", res, 8'h00);
        check("mid_rst_S", S, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_result", res_valid, 1'b0);
            check("post_rst_idle", in_ready, 1'b1);
        end

        for (int n = 0; n < 30; n++) begin
            run_cmd(8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
        end

        // Back-to-back: in_valid and res_ready held high, new command presented on each accept.
        res_ready = 1'b1;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rop = 2'($urandom);
            a = ra; b = rb; op = rop;
            model(ra, rb, rop, er, ec, ez);
            check("b2b_accept_ready", in_ready, 1'b1);
            tick();
            check("b2b_exec", in_ready, 1'b0);
            tick();
            check("b2b_valid", res_valid, 1'b1);
            check("b2b_res", res, er);
            check("b2b_flags", {carry, zero}, {ec, ez});
            tick();
        end
        in_valid = 1'b0;
        res_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
